// File: rtl/draw_datapath.sv
// draw_datapath: datapath partner of the race-game drawing FSM.
//
// Turns the FSM's one-hot draw-mode strobes and its inc/plot/done controls into
// row/column counters, registered VGA pixel writes and the stored car position.
// The FSM owns the row-end and pass-end decisions. This block only counts, clips
// and colours.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   draw_bg_green_left      mode: left verge, green
//   draw_bg_black           mode: road, black
//   draw_bg_green_right     mode: right verge, green
//   draw_car                mode: car at car_x, red
//   erase                   mode: repaint road black (counterx relative to road edge)
//   update_car              mode: apply pending move on entry, then draw car red
//   inc                     end of row: counterx to mode start, countery + 1
//   plot                    pixel-write enable from FSM
//   done                    pass complete: clear counters and mode history
//   move_left, move_right   player move requests (single-cycle pulses)
//   counterx, countery      counters back to the FSM
//   x, y, colour, writeEn   registered pixel write to the VGA adapter
//   car_x                   current car left column
module draw_datapath #(
  parameter int unsigned ROAD_X0    = 30,
  parameter int unsigned GREEN_R_X0 = 130,
  parameter int unsigned ROAD_X1    = 129,
  parameter int unsigned CAR_W      = 5,
  parameter int unsigned CAR_H      = 12,
  parameter int unsigned CAR_Y      = 100,
  parameter int unsigned CAR_X_INIT = 78,
  parameter int unsigned STEP       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       draw_bg_green_left,
  input  logic       draw_bg_black,
  input  logic       draw_bg_green_right,
  input  logic       draw_car,
  input  logic       erase,
  input  logic       update_car,
  input  logic       inc,
  input  logic       plot,
  input  logic       done,
  input  logic       move_left,
  input  logic       move_right,
  output logic [7:0] counterx,
  output logic [7:0] countery,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic [7:0] car_x
);

  localparam int unsigned ScreenW = 160;
  localparam int unsigned ScreenH = 120;
  localparam int unsigned CarXMax = ROAD_X1 - CAR_W + 1;

  localparam logic [2:0] ColGreen = 3'b010;
  localparam logic [2:0] ColBlack = 3'b000;
  localparam logic [2:0] ColRed   = 3'b100;

  typedef enum logic [2:0] {
    ModeNone,
    ModeGreenL,
    ModeBlack,
    ModeGreenR,
    ModeCar,
    ModeErase,
    ModeUpdate
  } mode_e;

  mode_e mode, mode_q;
  logic  entry, steady, upd_entry;
  logic  pending_l, pending_r;

  logic [7:0] x_start;
  logic [8:0] px, py;
  logic       clip_ok, pix_valid;
  logic [2:0] pix_colour;

  logic [8:0] car9, car_left, car_right;
  logic [7:0] car_next;

  // Priority decode of the mode strobes (they should be one-hot anyway).
  always_comb begin
    mode = ModeNone;
    if (draw_bg_green_left)       mode = ModeGreenL;
    else if (draw_bg_black)       mode = ModeBlack;
    else if (draw_bg_green_right) mode = ModeGreenR;
    else if (draw_car)            mode = ModeCar;
    else if (erase)               mode = ModeErase;
    else if (update_car)          mode = ModeUpdate;
  end

  assign entry     = (mode != ModeNone) && (mode != mode_q);
  assign steady    = (mode != ModeNone) && (mode == mode_q);
  assign upd_entry = entry && (mode == ModeUpdate);

  always_comb begin
    x_start = 8'd0;
    case (mode)
      ModeBlack:  x_start = 8'(ROAD_X0);
      ModeGreenR: x_start = 8'(GREEN_R_X0);
      default:    x_start = 8'd0;
    endcase
  end

  // Pixel coordinates are formed in 9 bits so car/erase offsets cannot wrap
  // back onto the screen.
  always_comb begin
    px         = {1'b0, counterx};
    py         = {1'b0, countery};
    clip_ok    = 1'b0;
    pix_colour = ColBlack;
    case (mode)
      ModeGreenL, ModeGreenR: begin
        clip_ok    = 1'b1;
        pix_colour = ColGreen;
      end
      ModeBlack: begin
        clip_ok    = 1'b1;
        pix_colour = ColBlack;
      end
      ModeCar, ModeUpdate: begin
        px         = {1'b0, car_x} + {1'b0, counterx};
        py         = 9'(CAR_Y) + {1'b0, countery};
        clip_ok    = ({1'b0, countery} < 9'(CAR_H));
        pix_colour = ColRed;
      end
      ModeErase: begin
        px         = 9'(ROAD_X0) + {1'b0, counterx};
        clip_ok    = (px <= 9'(ROAD_X1));
        pix_colour = ColBlack;
      end
      default: begin
        clip_ok    = 1'b0;
        pix_colour = ColBlack;
      end
    endcase
  end

  assign pix_valid = plot && steady && clip_ok &&
                     (px < 9'(ScreenW)) && (py < 9'(ScreenH));

  // Clamped car moves. Both requests pending cancel each other.
  assign car9      = {1'b0, car_x};
  assign car_left  = (car9 >= 9'(ROAD_X0 + STEP)) ? (car9 - 9'(STEP)) : 9'(ROAD_X0);
  assign car_right = ((car9 + 9'(STEP)) > 9'(CarXMax)) ? 9'(CarXMax) : (car9 + 9'(STEP));

  always_comb begin
    car_next = car_x;
    if (pending_l && !pending_r)      car_next = car_left[7:0];
    else if (pending_r && !pending_l) car_next = car_right[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q    <= ModeNone;
      counterx  <= 8'd0;
      countery  <= 8'd0;
      x         <= 8'd0;
      y         <= 7'd0;
      colour    <= 3'd0;
      writeEn   <= 1'b0;
      car_x     <= 8'(CAR_X_INIT);
      pending_l <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      mode_q <= done ? ModeNone : mode;

      if (done) begin
        counterx <= 8'd0;
        countery <= 8'd0;
      end else if (entry) begin
        counterx <= x_start;
        countery <= 8'd0;
      end else if (steady) begin
        if (inc) begin
          counterx <= x_start;
          countery <= countery + 8'd1;
        end else begin
          counterx <= counterx + 8'd1;
        end
      end

      writeEn <= pix_valid;
      if (pix_valid) begin
        x      <= px[7:0];
        y      <= py[6:0];
        colour <= pix_colour;
      end

      // A request arriving on the update entry cycle survives the clear.
      pending_l <= (pending_l && !upd_entry) || move_left;
      pending_r <= (pending_r && !upd_entry) || move_right;
      if (upd_entry) car_x <= car_next;
    end
  end

endmodule

// File: tb/tb_draw_datapath.sv
module tb_draw_datapath;

  logic       clock = 1'b0;
  logic       reset;
  logic       gl, bk, gr, dc, er, uc;
  logic       inc, plot, done, move_left, move_right;
  logic [7:0] counterx, countery, x, car_x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  draw_datapath dut (
    .clock               (clock),
    .reset               (reset),
    .draw_bg_green_left  (gl),
    .draw_bg_black       (bk),
    .draw_bg_green_right (gr),
    .draw_car            (dc),
    .erase               (er),
    .update_car          (uc),
    .inc                 (inc),
    .plot                (plot),
    .done                (done),
    .move_left           (move_left),
    .move_right          (move_right),
    .counterx            (counterx),
    .countery            (countery),
    .x                   (x),
    .y                   (y),
    .colour              (colour),
    .writeEn             (writeEn),
    .car_x               (car_x)
  );

  typedef struct {
    bit ml;
    bit mr;
    int reps;
    int exp_carx;
  } mv_t;

  mv_t vec[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Mode codes: 0 none, 1 green-left, 2 black, 3 green-right, 4 car, 5 erase, 6 update.
  task automatic set_mode(input int m);
    gl = (m == 1);
    bk = (m == 2);
    gr = (m == 3);
    dc = (m == 4);
    er = (m == 5);
    uc = (m == 6);
  endtask

  function automatic int mode_colour(input int m);
    if (m == 1 || m == 3) return 2;
    if (m == 4 || m == 6) return 4;
    return 0;
  endfunction

  function automatic void model_pixel(input int m, input int cx, input int cy, input int carx,
                                      output bit v, output int px, output int py);
    bit extra;
    px = cx;
    py = cy;
    extra = 1'b1;
    if (m == 4 || m == 6) begin
      px = carx + cx;
      py = 100 + cy;
      extra = (cy < 12);
    end else if (m == 5) begin
      px = 30 + cx;
      extra = (px <= 129);
    end
    v = extra && (px < 160) && (py < 120);
  endfunction

  // Plays the FSM role for one pass and compares every cycle against the model.
  task automatic run_pass(input string name, input int m, input int xstart, input int xend,
                          input int yterm, input int carx, input bit do_done,
                          output int writes, output int minx, output int maxx,
                          output int miny, output int maxy, output int firstx,
                          output int firsty);
    int cx, cy, bad, n, ex, ey, col;
    bit ev, term;
    col = mode_colour(m);
    set_mode(m);
    plot = 1'b1;
    inc  = 1'b0;
    done = 1'b0;
    tick();
    check({name, " entry counterx"}, int'(counterx), xstart);
    check({name, " entry countery"}, int'(countery), 0);
    check({name, " entry writeEn"}, int'(writeEn), 0);
    cx = xstart; cy = 0; bad = 0; n = 0; term = 1'b0;
    writes = 0; minx = 999; maxx = -1; miny = 999; maxy = -1; firstx = -1; firsty = -1;
    while (!term && n < 20000) begin
      if (int'(counterx) != cx || int'(countery) != cy) bad++;
      term = (cy == yterm);
      inc  = !term && (cx == xend);
      model_pixel(m, cx, cy, carx, ev, ex, ey);
      tick();
      n++;
      if (writeEn !== ev) begin
        bad++;
      end else if (ev) begin
        if (int'(x) != ex || int'(y) != ey || int'(colour) != col) bad++;
        if (writes == 0) begin
          firstx = int'(x);
          firsty = int'(y);
        end
        writes++;
        if (int'(x) < minx) minx = int'(x);
        if (int'(x) > maxx) maxx = int'(x);
        if (int'(y) < miny) miny = int'(y);
        if (int'(y) > maxy) maxy = int'(y);
      end
      if (inc) begin
        cx = xstart;
        cy++;
      end else begin
        cx++;
      end
    end
    check({name, " reached terminal row"}, int'(term), 1);
    check({name, " per-cycle mismatches"}, bad, 0);
    inc = 1'b0;
    if (do_done) begin
      set_mode(0);
      done = 1'b1;
      tick();
      done = 1'b0;
      check({name, " done clears counters"}, int'(counterx) + int'(countery), 0);
    end
  endtask

  task automatic pulse_move(input bit ml, input bit mr);
    move_left  = ml;
    move_right = mr;
    tick();
    move_left  = 1'b0;
    move_right = 1'b0;
  endtask

  task automatic do_update();
    set_mode(6);
    plot = 1'b0;
    tick();
    set_mode(0);
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    int w, mnx, mxx, mny, mxy, fx, fy, acc;

    vec[0]  = '{1'b1, 1'b0, 1, 70};
    vec[1]  = '{1'b0, 1'b1, 1, 74};
    vec[2]  = '{1'b1, 1'b1, 1, 74};
    vec[3]  = '{1'b0, 1'b0, 1, 74};
    vec[4]  = '{1'b1, 1'b0, 10, 34};
    vec[5]  = '{1'b1, 1'b0, 1, 30};
    vec[6]  = '{1'b1, 1'b0, 1, 30};
    vec[7]  = '{1'b0, 1'b1, 23, 122};
    vec[8]  = '{1'b0, 1'b1, 1, 125};
    vec[9]  = '{1'b0, 1'b1, 1, 125};
    vec[10] = '{1'b1, 1'b0, 1, 121};

    reset = 1'b1;
    set_mode(0);
    inc = 1'b0; plot = 1'b0; done = 1'b0; move_left = 1'b0; move_right = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset counterx", int'(counterx), 0);
    check("reset countery", int'(countery), 0);
    check("reset x/y/colour", int'(x) + int'(y) + int'(colour), 0);
    check("reset writeEn", int'(writeEn), 0);
    check("reset car_x", int'(car_x), 78);

    // Left verge, then straight into black without done.
    run_pass("green_left", 1, 0, 30, 120, 78, 1'b0, w, mnx, mxx, mny, mxy, fx, fy);
    check("green_left writes", w, 31 * 120);
    check("green_left max x", mxx, 30);
    check("green_left max y", mxy, 119);
    check("green_left first x", fx, 0);
    run_pass("black", 2, 30, 130, 120, 78, 1'b1, w, mnx, mxx, mny, mxy, fx, fy);
    check("black writes", w, 101 * 120);
    check("black first x", fx, 30);
    check("black first y", fy, 0);
    check("black max x", mxx, 130);
    run_pass("green_right", 3, 130, 160, 120, 78, 1'b1, w, mnx, mxx, mny, mxy, fx, fy);
    check("green_right writes", w, 30 * 120);
    check("green_right max x", mxx, 159);

    run_pass("car", 4, 0, 4, 12, 78, 1'b1, w, mnx, mxx, mny, mxy, fx, fy);
    check("car writes", w, 60);
    check("car min x", mnx, 78);
    check("car max x", mxx, 82);
    check("car min y", mny, 100);
    check("car max y", mxy, 111);

    // Three left requests collapse into one pending move.
    for (int i = 0; i < 3; i++) begin
      pulse_move(1'b1, 1'b0);
      tick();
    end
    run_pass("update", 6, 0, 4, 12, 74, 1'b1, w, mnx, mxx, mny, mxy, fx, fy);
    check("update car_x", int'(car_x), 74);
    check("update writes", w, 60);
    check("update min x", mnx, 74);
    do_update();
    check("pending cleared", int'(car_x), 74);

    for (int i = 0; i < 11; i++) begin
      for (int r = 0; r < vec[i].reps; r++) begin
        pulse_move(vec[i].ml, vec[i].mr);
        do_update();
      end
      check($sformatf("move vec %0d car_x", i), int'(car_x), vec[i].exp_carx);
    end

    // A request on the update entry cycle is kept for the next update.
    set_mode(6);
    plot = 1'b0;
    move_right = 1'b1;
    tick();
    move_right = 1'b0;
    set_mode(0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("same-cycle request no move", int'(car_x), 121);
    do_update();
    check("same-cycle request kept", int'(car_x), 125);

    run_pass("erase", 5, 0, 100, 120, 125, 1'b1, w, mnx, mxx, mny, mxy, fx, fy);
    check("erase writes", w, 100 * 120);
    check("erase min x", mnx, 30);
    check("erase max x", mxx, 129);

    // Reset in the middle of an erase with a move pending.
    set_mode(5);
    plot = 1'b1;
    inc = 1'b0;
    move_left = 1'b1;
    tick();
    move_left = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("mid-erase writing before reset", int'(writeEn), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_mode(0);
    check("mid reset counters", int'(counterx) + int'(countery), 0);
    check("mid reset x/y/colour", int'(x) + int'(y) + int'(colour), 0);
    check("mid reset writeEn", int'(writeEn), 0);
    check("mid reset car_x", int'(car_x), 78);
    inc = 1'b1;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acc += int'(writeEn) + int'(counterx) + int'(countery);
    end
    inc = 1'b0;
    check("idle after reset quiet", acc, 0);
    do_update();
    check("reset cleared pending", int'(car_x), 78);
    set_mode(5);
    plot = 1'b1;
    tick();
    check("post-reset entry writeEn", int'(writeEn), 0);
    tick();
    check("post-reset first write", int'(writeEn), 1);
    check("post-reset first x", int'(x), 30);
    set_mode(0);
    plot = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
